vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_gen.sv | 166 ++++++++++++++++
 tb/tb_vga_timing_gen.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: X/Y position, sync, blank, data-enable,
// line/frame strobes and a completed-frame counter. X/Y lead the sync/blank
// outputs by LEAD pixel-enabled steps so a pipelined pixel source lines up.
module vga_timing_gen #(
  parameter int W     = 640,
  parameter int H     = 480,
  parameter int HFP   = 16,
  parameter int HSYNC = 96,
  parameter int HBP   = 48,
  parameter int VFP   = 10,
  parameter int VSYNC = 2,
  parameter int VBP   = 33,
  parameter int HPOL  = 0,
  parameter int VPOL  = 0,
  parameter int LEAD  = 0,
  parameter int XW    = 11,
  parameter int YW    = 10,
  parameter int FW    = 8
) (
  input  logic          CLK,
  input  logic          RST_,
  input  logic          CE,
  input  logic          EN,
  output logic [XW-1:0] X,
  output logic [YW-1:0] Y,
  output logic          SOL,
  output logic          SOF,
  output logic          HB,
  output logic          VB,
  output logic          DE,
  output logic          HS,
  output logic          VS,
  output logic [FW-1:0] FRAME
);

  // Raster geometry
  localparam int HTOTAL   = W + HFP + HSYNC + HBP;
  localparam int VTOTAL   = H + VFP + VSYNC + VBP;
  localparam int HS_START = W + HFP;
  localparam int HS_END   = W + HFP + HSYNC;
  localparam int VS_START = H + VFP;
  localparam int VS_END   = H + VFP + VSYNC;

  localparam logic HPOL_L = (HPOL != 0);
  localparam logic VPOL_L = (VPOL != 0);

  // Sized compare constants; the sync end bounds get one extra bit because
  // a zero back porch puts them exactly at HTOTAL/VTOTAL.
  localparam logic [XW-1:0] X_LAST  = XW'(HTOTAL - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(VTOTAL - 1);
  localparam logic [XW-1:0] X_ACT   = XW'(W);
  localparam logic [YW-1:0] Y_ACT   = YW'(H);
  localparam logic [XW:0]   X_HS0   = (XW+1)'(HS_START);
  localparam logic [XW:0]   X_HS1   = (XW+1)'(HS_END);
  localparam logic [YW:0]   Y_VS0   = (YW+1)'(VS_START);
  localparam logic [YW:0]   Y_VS1   = (YW+1)'(VS_END);

  // Video control word layout: {hb, vb, de, hs, vs}
  localparam logic [4:0] BLANK = {1'b1, 1'b1, 1'b0, ~HPOL_L, ~VPOL_L};

  // Reject illegal configurations at elaboration
  if (LEAD < 0 || LEAD > 4) begin : g_bad_lead
    $error("vga_timing_gen: LEAD must be in 0..4");
  end
  if ((HTOTAL - 1) >= (2 ** XW)) begin : g_bad_xw
    $error("vga_timing_gen: XW too small for HTOTAL-1");
  end
  if ((VTOTAL - 1) >= (2 ** YW)) begin : g_bad_yw
    $error("vga_timing_gen: YW too small for VTOTAL-1");
  end

  logic [XW-1:0] x_r;
  logic [YW-1:0] y_r;
  logic [FW-1:0] frame_r;
  logic          x_last_s;
  logic          y_last_s;
  logic [4:0]    raw_s;
  logic [4:0]    vid_s;

  assign x_last_s = (x_r == X_LAST);
  assign y_last_s = (y_r == Y_LAST);

  // Position counters: EN low parks the raster at the origin, CE gates stepping
  always_ff @(posedge CLK or negedge RST_) begin
    if (!RST_) begin
      x_r <= '0;
      y_r <= '0;
    end else if (!EN) begin
      x_r <= '0;
      y_r <= '0;
    end else if (CE) begin
      if (x_last_s) begin
        x_r <= '0;
        y_r <= y_last_s ? '0 : y_r + YW'(1);
      end else begin
        x_r <= x_r + XW'(1);
      end
    end
  end

  // Completed-frame counter, bumped on the step that leaves the last pixel
  always_ff @(posedge CLK or negedge RST_) begin
    if (!RST_) begin
      frame_r <= '0;
    end else if (EN && CE && x_last_s && y_last_s) begin
      frame_r <= frame_r + FW'(1);
    end
  end

  // Raw decode of the current lead position
  always_comb begin
    logic hb_v;
    logic vb_v;
    logic hs_act_v;
    logic vs_act_v;
    hb_v     = (x_r >= X_ACT);
    vb_v     = (y_r >= Y_ACT);
    hs_act_v = ({1'b0, x_r} >= X_HS0) && ({1'b0, x_r} < X_HS1);
    vs_act_v = ({1'b0, y_r} >= Y_VS0) && ({1'b0, y_r} < Y_VS1);
    raw_s    = {hb_v, vb_v, (!hb_v && !vb_v),
                (hs_act_v ? HPOL_L : ~HPOL_L),
                (vs_act_v ? VPOL_L : ~VPOL_L)};
  end

  if (LEAD == 0) begin : g_direct
    // No delay stages: drive the decode straight out, blanked while stopped
    always_comb begin
      if (!EN) begin
        vid_s = BLANK;
      end else begin
        vid_s = raw_s;
      end
    end
  end else begin : g_pipe
    logic [4:0] pipe_r [LEAD];

    // Delay line: shifts the decode along on pixel-enabled steps only
    always_ff @(posedge CLK or negedge RST_) begin
      if (!RST_) begin
        for (int i = 0; i < LEAD; i++) pipe_r[i] <= BLANK;
      end else if (!EN) begin
        for (int i = 0; i < LEAD; i++) pipe_r[i] <= BLANK;
      end else if (CE) begin
        pipe_r[0] <= raw_s;
        for (int i = 1; i < LEAD; i++) pipe_r[i] <= pipe_r[i-1];
      end
    end

    // Last stage is the visible timing
    always_comb begin
      vid_s = pipe_r[LEAD-1];
    end
  end

  assign X     = x_r;
  assign Y     = y_r;
  assign FRAME = frame_r;
  assign HB    = vid_s[4];
  assign VB    = vid_s[3];
  assign DE    = vid_s[2];
  assign HS    = vid_s[1];
  assign VS    = vid_s[0];
  assign SOL   = EN && CE && (x_r == '0);
  assign SOF   = SOL && (y_r == '0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a default 640x480 instance, a tiny
// 7x5 raster with positive syncs, and the same tiny raster with LEAD=2.
module tb_vga_timing_gen;

  logic CLK = 1'b0;
  logic RST_, CE, EN;
  int   checks = 0;
  int   errors = 0;

  always #5 CLK = ~CLK;

  // Default-mode instance
  logic [10:0] d_x;
  logic [9:0]  d_y;
  logic [7:0]  d_frame;
  logic d_sol, d_sof, d_hb, d_vb, d_de, d_hs, d_vs;

  vga_timing_gen dut_d (
    .CLK(CLK), .RST_(RST_), .CE(CE), .EN(EN), .X(d_x), .Y(d_y),
    .SOL(d_sol), .SOF(d_sof), .HB(d_hb), .VB(d_vb), .DE(d_de),
    .HS(d_hs), .VS(d_vs), .FRAME(d_frame));

  // Tiny raster, active-high syncs: HTOTAL=7, VTOTAL=5
  logic [2:0] s_x, s_y;
  logic [7:0] s_frame;
  logic s_sol, s_sof, s_hb, s_vb, s_de, s_hs, s_vs;

  vga_timing_gen #(.W(4), .H(2), .HFP(1), .HSYNC(1), .HBP(1), .VFP(1),
                   .VSYNC(1), .VBP(1), .HPOL(1), .VPOL(1), .LEAD(0),
                   .XW(3), .YW(3), .FW(8)) dut_s (
    .CLK(CLK), .RST_(RST_), .CE(CE), .EN(EN), .X(s_x), .Y(s_y),
    .SOL(s_sol), .SOF(s_sof), .HB(s_hb), .VB(s_vb), .DE(s_de),
    .HS(s_hs), .VS(s_vs), .FRAME(s_frame));

  // Tiny raster, active-low syncs, two lead stages
  logic [2:0] l_x, l_y;
  logic [7:0] l_frame;
  logic l_sol, l_sof, l_hb, l_vb, l_de, l_hs, l_vs;

  vga_timing_gen #(.W(4), .H(2), .HFP(1), .HSYNC(1), .HBP(1), .VFP(1),
                   .VSYNC(1), .VBP(1), .HPOL(0), .VPOL(0), .LEAD(2),
                   .XW(3), .YW(3), .FW(8)) dut_l (
    .CLK(CLK), .RST_(RST_), .CE(CE), .EN(EN), .X(l_x), .Y(l_y),
    .SOL(l_sol), .SOF(l_sof), .HB(l_hb), .VB(l_vb), .DE(l_de),
    .HS(l_hs), .VS(l_vs), .FRAME(l_frame));

  // Expected {hb,vb,de,hs,vs} of the tiny raster at step n; pol picks sync level
  function automatic logic [4:0] tiny_vid(input int n, input logic pol);
    int x, y;
    logic hb, vb;
    x  = n % 7;
    y  = (n / 7) % 5;
    hb = (x >= 4);
    vb = (y >= 2);
    return {hb, vb, !hb && !vb, (x == 5) ? pol : !pol, (y == 3) ? pol : !pol};
  endfunction

  // Expected lead-2 timing after n steps: blank for the first two
  function automatic logic [4:0] lead_vid(input int n);
    if (n < 2) return 5'b11011;
    return tiny_vid(n - 2, 1'b0);
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST_ = 1'b0; CE = 1'b1; EN = 1'b1;
    repeat (2) tick();
    checks++; if (d_x !== 11'd0 || d_y !== 10'd0) begin errors++; $display("FAIL reset_xy got %0d,%0d want 0,0", d_x, d_y); end
    checks++; if (d_frame !== 8'd0) begin errors++; $display("FAIL reset_frame got %0d want 0", d_frame); end
    checks++; if ({d_hb, d_vb, d_de, d_hs, d_vs} !== 5'b00111) begin errors++; $display("FAIL reset_vid_lead0 got %b want 00111", {d_hb, d_vb, d_de, d_hs, d_vs}); end
    checks++; if ({d_sol, d_sof} !== 2'b11) begin errors++; $display("FAIL reset_strobes got %b want 11", {d_sol, d_sof}); end
    checks++; if ({l_hb, l_vb, l_de, l_hs, l_vs} !== 5'b11011) begin errors++; $display("FAIL reset_vid_lead2 got %b want 11011", {l_hb, l_vb, l_de, l_hs, l_vs}); end
    checks++; if (s_frame !== 8'd0 || l_frame !== 8'd0) begin errors++; $display("FAIL reset_frame_tiny got %0d,%0d want 0,0", s_frame, l_frame); end
    RST_ = 1'b1;
  endtask

  task automatic test_default_line();
    logic [4:0] exp;
    for (int k = 0; k < 800; k++) begin
      exp = {(k >= 640), 1'b0, (k < 640), !(k >= 656 && k <= 751), 1'b1};
      checks++; if (d_x !== 11'(k) || d_y !== 10'd0) begin errors++; $display("FAIL line_xy got %0d,%0d want %0d,0", d_x, d_y, k); end
      checks++; if ({d_hb, d_vb, d_de, d_hs, d_vs} !== exp) begin errors++; $display("FAIL line_vid x=%0d got %b want %b", k, {d_hb, d_vb, d_de, d_hs, d_vs}, exp); end
      checks++; if ({d_sol, d_sof} !== {2{k == 0}}) begin errors++; $display("FAIL line_strobes x=%0d got %b", k, {d_sol, d_sof}); end
      tick();
    end
    checks++; if (d_x !== 11'd0 || d_y !== 10'd1) begin errors++; $display("FAIL line_wrap got %0d,%0d want 0,1", d_x, d_y); end
    checks++; if ({d_sol, d_sof} !== 2'b10) begin errors++; $display("FAIL line_wrap_strobes got %b want 10", {d_sol, d_sof}); end
  endtask

  task automatic test_en_drop();
    repeat (300) tick();
    checks++; if (d_x !== 11'd300 || d_y !== 10'd1) begin errors++; $display("FAIL en_pre_xy got %0d,%0d want 300,1", d_x, d_y); end
    EN = 1'b0;
    tick();
    checks++; if (d_x !== 11'd0 || d_y !== 10'd0) begin errors++; $display("FAIL en_xy got %0d,%0d want 0,0", d_x, d_y); end
    checks++; if ({d_hb, d_vb, d_de, d_hs, d_vs} !== 5'b11011) begin errors++; $display("FAIL en_vid got %b want 11011", {d_hb, d_vb, d_de, d_hs, d_vs}); end
    checks++; if (d_sol !== 1'b0) begin errors++; $display("FAIL en_sol got %b want 0", d_sol); end
    checks++; if (s_x !== 3'd0 || s_y !== 3'd0 || s_frame !== 8'd31) begin errors++; $display("FAIL en_tiny got %0d,%0d f=%0d want 0,0 f=31", s_x, s_y, s_frame); end
    checks++; if ({s_hb, s_vb, s_de, s_hs, s_vs} !== 5'b11000) begin errors++; $display("FAIL en_tiny_vid got %b want 11000", {s_hb, s_vb, s_de, s_hs, s_vs}); end
    checks++; if ({l_hb, l_vb, l_de, l_hs, l_vs} !== 5'b11011 || l_frame !== 8'd31) begin errors++; $display("FAIL en_lead_vid got %b f=%0d want 11011 f=31", {l_hb, l_vb, l_de, l_hs, l_vs}, l_frame); end
    EN = 1'b1;
    #1;
    checks++; if ({d_sof, s_sof} !== 2'b11) begin errors++; $display("FAIL en_restart_sof got %b want 11", {d_sof, s_sof}); end
    for (int t = 1; t <= 35; t++) begin
      tick();
      checks++; if (d_x !== 11'(t) || d_y !== 10'd0 || d_frame !== 8'd0) begin errors++; $display("FAIL en_run_d got %0d,%0d f=%0d want %0d,0 f=0", d_x, d_y, d_frame, t); end
      checks++; if (s_frame !== ((t == 35) ? 8'd32 : 8'd31)) begin errors++; $display("FAIL en_run_frame t=%0d got %0d", t, s_frame); end
    end
  endtask

  task automatic test_async_reset();
    repeat (465) tick();
    checks++; if (d_x !== 11'd500) begin errors++; $display("FAIL ar_pre_x got %0d want 500", d_x); end
    #3 RST_ = 1'b0;
    #1;
    checks++; if (d_x !== 11'd0 || d_y !== 10'd0 || d_frame !== 8'd0) begin errors++; $display("FAIL ar_d got %0d,%0d f=%0d want 0,0 f=0", d_x, d_y, d_frame); end
    checks++; if (s_x !== 3'd0 || s_frame !== 8'd0) begin errors++; $display("FAIL ar_tiny got x=%0d f=%0d want 0,0", s_x, s_frame); end
    checks++; if (d_de !== 1'b1 || {l_hb, l_vb, l_de, l_hs, l_vs} !== 5'b11011) begin errors++; $display("FAIL ar_vid got de=%b lead=%b", d_de, {l_hb, l_vb, l_de, l_hs, l_vs}); end
    RST_ = 1'b1;
    tick();
    checks++; if (d_x !== 11'd1 || d_y !== 10'd0 || s_x !== 3'd1) begin errors++; $display("FAIL ar_resume got %0d,%0d s=%0d want 1,0 s=1", d_x, d_y, s_x); end
  endtask

  task automatic test_tiny_frames();
    RST_ = 1'b0;
    #1 RST_ = 1'b1;
    for (int k = 0; k < 105; k++) begin
      checks++; if (s_x !== 3'(k % 7) || s_y !== 3'((k / 7) % 5)) begin errors++; $display("FAIL tiny_xy k=%0d got %0d,%0d", k, s_x, s_y); end
      checks++; if ({s_hb, s_vb, s_de, s_hs, s_vs} !== tiny_vid(k, 1'b1)) begin errors++; $display("FAIL tiny_vid k=%0d got %b want %b", k, {s_hb, s_vb, s_de, s_hs, s_vs}, tiny_vid(k, 1'b1)); end
      checks++; if (s_sof !== (k % 35 == 0)) begin errors++; $display("FAIL tiny_sof k=%0d got %b", k, s_sof); end
      checks++; if (s_frame !== 8'(k / 35)) begin errors++; $display("FAIL tiny_frame k=%0d got %0d want %0d", k, s_frame, k / 35); end
      checks++; if ({l_hb, l_vb, l_de, l_hs, l_vs} !== lead_vid(k) || l_x !== s_x) begin errors++; $display("FAIL lead_vid k=%0d got %b want %b", k, {l_hb, l_vb, l_de, l_hs, l_vs}, lead_vid(k)); end
      tick();
    end
  endtask

  task automatic test_ce_toggle();
    int n = 0;
    RST_ = 1'b0;
    #1 RST_ = 1'b1;
    for (int c = 0; c < 140; c++) begin
      CE = (c % 2 == 0);
      tick();
      if (CE) n++;
      checks++; if (s_x !== 3'(n % 7) || s_y !== 3'((n / 7) % 5)) begin errors++; $display("FAIL ce_xy c=%0d got %0d,%0d", c, s_x, s_y); end
      checks++; if (s_frame !== 8'(n / 35)) begin errors++; $display("FAIL ce_frame c=%0d got %0d want %0d", c, s_frame, n / 35); end
      checks++; if ({s_hb, s_vb, s_de, s_hs, s_vs} !== tiny_vid(n, 1'b1)) begin errors++; $display("FAIL ce_vid c=%0d got %b", c, {s_hb, s_vb, s_de, s_hs, s_vs}); end
      checks++; if ({l_hb, l_vb, l_de, l_hs, l_vs} !== lead_vid(n)) begin errors++; $display("FAIL ce_lead c=%0d got %b want %b", c, {l_hb, l_vb, l_de, l_hs, l_vs}, lead_vid(n)); end
    end
    CE = 1'b1;
  endtask

  initial begin
    test_reset();
    test_default_line();
    test_en_drop();
    test_async_reset();
    test_tiny_frames();
    test_ce_toggle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
